// File: rtl/pipeline_elastic_chain.sv
// Multi-stage elastic register chain with valid/ready handshaking, global hold,
// synchronous flush and bubble collapsing.
module pipeline_elastic_chain #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 3,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] occupancy
);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH:0]   acc;
    logic [DEPTH-1:0] up_v;
    logic [WIDTH-1:0] up_d [DEPTH];
    logic             in_xfer;
    logic             out_xfer;

    // A stage can take a new entry when it is empty or its own entry moves on,
    // which is what lets entries collapse into bubbles while the tail is blocked.
    always_comb begin
        acc        = '0;
        acc[DEPTH] = out_ready;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            acc[DEPTH-1-k] = ~hold & (~v[DEPTH-1-k] | acc[DEPTH-k]);
        end
    end

    always_comb begin
        up_v    = '0;
        up_v[0] = in_valid;
        up_d[0] = in_data;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            up_v[k] = v[k-1];
            up_d[k] = d[k-1];
        end
    end

    assign in_ready  = acc[0] & ~flush;
    assign out_valid = v[DEPTH-1] & ~hold;
    assign out_data  = d[DEPTH-1];
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready & ~flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v         <= '0;
            occupancy <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                d[k] <= '0;
            end
        end else if (flush) begin
            v         <= '0;
            occupancy <= '0;
        end else begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (acc[k]) begin
                    v[k] <= up_v[k];
                    if (up_v[k]) begin
                        d[k] <= up_d[k];
                    end
                end
            end
            unique case ({in_xfer, out_xfer})
                2'b10:   occupancy <= occupancy + CNT_W'(1);
                2'b01:   occupancy <= occupancy - CNT_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_elastic_chain.sv
// Bench for pipeline_elastic_chain (WIDTH=8, DEPTH=3): scenario tasks plus a
// scoreboard that checks every output transfer against accepted inputs in order.
module tb_pipeline_elastic_chain;

    logic       clk = 1'b0;
    logic       reset;
    logic       hold;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [1:0] occupancy;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [7:0]  sb [$];

    pipeline_elastic_chain #(.WIDTH(8), .DEPTH(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .hold      (hold),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge, so values at the falling edge
    // decide what transfers on the next rising edge.
    always @(negedge clk) begin
        if (reset) begin
            if (flush) begin
                sb.delete();
            end else begin
                if (out_valid && out_ready) begin
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL sb_unexpected: got out_data=%02h, expected no output", out_data);
                    end else begin
                        logic [7:0] exp_d;
                        exp_d = sb.pop_front();
                        if (out_data !== exp_d) begin
                            failures++;
                            $display("FAIL sb_order: got out_data=%02h, expected %02h", out_data, exp_d);
                        end
                    end
                end
                if (in_valid && in_ready) sb.push_back(in_data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        hold = 0; flush = 0; in_valid = 0; in_data = '0; out_ready = 0;
    endtask

    task automatic drain();
        int unsigned n;
        in_valid = 0; out_ready = 1; hold = 0; flush = 0;
        n = 0;
        while (occupancy != 0 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (occupancy !== 2'd0 || sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got occupancy=%0d pending=%0d, expected 0 and 0", occupancy, sb.size());
        end
        out_ready = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 0;
        step(); step();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state: got ov=%b od=%02h occ=%0d ir=%b, expected 0 00 0 1",
                     out_valid, out_data, occupancy, in_ready);
        end
        reset = 1;
        step();
    endtask

    task automatic test_stream();
        logic [7:0]  vals [6];
        logic        exp_ov;
        logic [1:0]  exp_occ;
        vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1; in_data = vals[i];
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL stream_ready[%0d]: got in_ready=%b, expected 1", i, in_ready);
            end
            step();
            exp_ov  = (i >= 2);
            exp_occ = (i >= 2) ? 2'd3 : 2'(i + 1);
            checks++;
            if (out_valid !== exp_ov || occupancy !== exp_occ) begin
                failures++;
                $display("FAIL stream_lat[%0d]: got ov=%b occ=%0d, expected ov=%b occ=%0d",
                         i, out_valid, occupancy, exp_ov, exp_occ);
            end
            if (i == 2) begin
                checks++;
                if (out_data !== 8'h11) begin
                    failures++;
                    $display("FAIL stream_first: got out_data=%02h, expected 11", out_data);
                end
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [7:0] vals [4];
        vals = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_data = vals[i];
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL bp_accept[%0d]: got in_ready=%b, expected 1", i, in_ready);
            end
            step();
        end
        in_data = vals[3];
        #1;
        checks++;
        if (in_ready !== 1'b0 || occupancy !== 2'd3) begin
            failures++;
            $display("FAIL bp_full: got ir=%b occ=%0d, expected ir=0 occ=3", in_ready, occupancy);
        end
        out_ready = 1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_passthru: got in_ready=%b, expected 1", in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== vals[i]) begin
                failures++;
                $display("FAIL bp_drain[%0d]: got ov=%b od=%02h, expected ov=1 od=%02h",
                         i, out_valid, out_data, vals[i]);
            end
            step();
            in_valid = 0;
        end
        drain();
    endtask

    task automatic test_bubble_collapse();
        out_ready = 0;
        in_valid = 1; in_data = 8'h01; step();
        in_valid = 0; step();
        in_valid = 1; in_data = 8'h02; step();
        in_valid = 0; step();
        checks++;
        if (occupancy !== 2'd2 || in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'h01) begin
            failures++;
            $display("FAIL bubble_state: got occ=%0d ir=%b ov=%b od=%02h, expected 2 1 1 01",
                     occupancy, in_ready, out_valid, out_data);
        end
        // Entries adjacent in stages 2 and 1 leave on consecutive cycles.
        out_ready = 1;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h02) begin
            failures++;
            $display("FAIL bubble_adjacent: got ov=%b od=%02h, expected 1 02", out_valid, out_data);
        end
        drain();
    endtask

    task automatic test_hold();
        out_ready = 0;
        in_valid = 1; in_data = 8'h5A; step();
        in_data = 8'h5B; step();
        in_valid = 0; step();
        hold = 1; in_valid = 1; in_data = 8'h77; out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || occupancy !== 2'd2 || out_data !== 8'h5A) begin
                failures++;
                $display("FAIL hold[%0d]: got ir=%b ov=%b occ=%0d od=%02h, expected 0 0 2 5A",
                         i, in_ready, out_valid, occupancy, out_data);
            end
            step();
        end
        hold = 0; in_valid = 0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h5A) begin
            failures++;
            $display("FAIL hold_release0: got ov=%b od=%02h, expected 1 5A", out_valid, out_data);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h5B) begin
            failures++;
            $display("FAIL hold_release1: got ov=%b od=%02h, expected 1 5B", out_valid, out_data);
        end
        drain();
    endtask

    task automatic test_flush(input logic with_hold);
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_data = 8'hB1 + 8'(i); step();
        end
        in_valid = 0;
        #1;
        checks++;
        if (occupancy !== 2'd3) begin
            failures++;
            $display("FAIL flush_fill(h=%b): got occ=%0d, expected 3", with_hold, occupancy);
        end
        flush = 1; hold = with_hold; in_valid = 1; in_data = 8'hFF; out_ready = 1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_ready(h=%b): got in_ready=%b, expected 0", with_hold, in_ready);
        end
        step();
        flush = 0; hold = 0; in_valid = 0;
        #1;
        checks++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_clear(h=%b): got occ=%0d ov=%b, expected 0 0", with_hold, occupancy, out_valid);
        end
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            failures++;
            $display("FAIL flush_ghost(h=%b): got ov=%b occ=%0d, expected 0 0", with_hold, out_valid, occupancy);
        end
        out_ready = 0;
    endtask

    task automatic test_async_reset();
        out_ready = 0;
        in_valid = 1; in_data = 8'hC1; step();
        in_data = 8'hC2; step();
        in_valid = 0;
        #2;
        reset = 0;
        sb.delete();
        #1;
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== 8'h00 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL async_reset: got ov=%b occ=%0d od=%02h ir=%b, expected 0 0 00 1",
                     out_valid, occupancy, out_data, in_ready);
        end
        step();
        reset = 1;
        out_ready = 1;
        in_valid = 1; in_data = 8'hD1; step();
        in_valid = 0;
        step(); step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hD1 || occupancy !== 2'd1) begin
            failures++;
            $display("FAIL post_reset: got ov=%b od=%02h occ=%0d, expected 1 D1 1", out_valid, out_data, occupancy);
        end
        drain();
    endtask

    initial begin
        reset = 0;
        idle_inputs();
        test_reset();
        test_stream();
        test_backpressure();
        test_bubble_collapse();
        test_hold();
        test_flush(1'b0);
        test_flush(1'b1);
        test_async_reset();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_elastic_chain.md
# pipeline_elastic_chain

Parametrised multi-stage elastic pipeline register chain with per-stage valid bits, valid/ready handshaking, a global hold, flush, and bubble collapsing. It generalises the single-width, single-depth stall register: the global hold plays the role of the LSU-wait stall, and it is used between core pipeline stages (fetch→decode→issue) wherever more than one slot of buffering is needed. Empty stages are filled while downstream is stalled, so a stall does not freeze bubbles in place.

## Interface
- WIDTH, 8, payload bits per stage
- DEPTH, 3, number of register stages (≥1)
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- hold  in  1  global freeze (e.g. any LSU waiting): no stage changes, no transfers
- flush  in  1  synchronous squash of all in-flight entries
- in_valid  in  1  upstream has data
- in_data  in  WIDTH  upstream payload
- in_ready  out  1  chain accepts in_data this cycle
- out_valid  out  1  stage DEPTH-1 holds data presented downstream
- out_data  out  WIDTH  payload of stage DEPTH-1
- out_ready  in  1  downstream accepts this cycle
- occupancy  out  CNT_W  number of valid stages

## Operation
- State: v[i] (valid) and d[i] (WIDTH) for i = 0..DEPTH-1; stage 0 is the input side.
- Accept chain (combinational): acc[DEPTH] = out_ready; acc[i] = ~hold & (~v[i] | acc[i+1]).
- in_ready = acc[0] & ~flush. out_valid = v[DEPTH-1] & ~hold. out_data = d[DEPTH-1] (always driven).
- Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
- Per-stage update when acc[i] & ~flush: v[i] <= (i==0 ? in_valid : v[i-1]); d[i] <= upstream data only when upstream valid is 1, else d[i] holds.
- When ~acc[i] (and no flush), v[i] and d[i] hold.
- hold=1: every acc[i]=0, so all state holds and in_ready=out_valid=0, regardless of out_ready/in_valid.
- flush=1: all v[i] <= 0 next edge; d[i] hold; in_data is dropped; there is no output transfer that cycle (out_valid is unaffected combinationally, but downstream must ignore a flush-cycle transfer). flush overrides hold.
- Bubble collapse: an entry advances into an empty stage even when downstream is blocked, so DEPTH entries are accepted before in_ready drops.
- occupancy: registered; +1 on an input transfer, −1 on an output transfer, unchanged when both or neither occur; 0 on flush. Always equals popcount(v). It never exceeds DEPTH or goes below 0.

## Timing
- Reset (reset=0, async): all v=0, all d=0, occupancy=0, so out_valid=0 and out_data=0; in_ready=1 if hold=0 and flush=0. Deassertion takes effect from the next rising edge.
- Latency with an empty chain, hold=0, out_ready=1: data accepted at edge N is out_valid after edge N+DEPTH-1 (DEPTH-cycle register latency). Throughput is 1/cycle.
- Full chain with out_ready=1: in_ready=1 in the same cycle (combinational pass-through), so the chain streams with no bubble.
- Full chain with out_ready=0: in_ready=0. Releasing out_ready raises in_ready in the same cycle.
- Reset asserted mid-stream: all entries are lost immediately, with no partial output.
- DEPTH=1: this is a single-entry register with a combinational ready pass-through.

## Test plan
- Reset then stream: WIDTH=8, DEPTH=3, out_ready=1, inputs 0x11,0x22,0x33 on consecutive cycles → out_data 0x11,0x22,0x33 on consecutive cycles, first output 3 edges after the first input; occupancy reaches 3 and then stays 3.
- Backpressure fill: out_ready=0, offer 0xA1..0xA4 → first 3 are accepted, in_ready=0 on the 4th, occupancy=3. Then out_ready=1 → 0xA1,0xA2,0xA3,0xA4 in order with no gap.
- Bubble collapse: load 0x01, idle one cycle, load 0x02, out_ready=0 → both reach stages 2 and 1 adjacently, occupancy=2, in_ready stays 1.
- Hold: with 2 entries, hold=1 for 4 cycles while in_valid=1 and out_ready=1 → in_ready=0, out_valid=0, state and occupancy unchanged. After release, order is preserved.
- Flush: occupancy=3, flush=1 with in_valid=1 (0xFF) → next cycle occupancy=0, out_valid=0, and 0xFF never appears. Repeat with hold=1: the flush still clears.
- Async reset mid-stream: drop reset between edges with 2 entries → out_valid=0 and occupancy=0 immediately, out_data=0.
